// File: rtl/controle_pkg.sv
// Shared definitions for the joystick front-end: axis direction codes, the
// auto-repeat state type and the axis encoder used by controle_joystick.
package controle_pkg;

  localparam logic [1:0] DIR_PARADO = 2'b00;
  localparam logic [1:0] DIR_POS    = 2'b01;
  localparam logic [1:0] DIR_NEG    = 2'b10;

  // Auto-repeat sequencer states, one sequencer per axis.
  typedef enum logic [1:0] {
    OCIOSO         = 2'b00,
    PULSO          = 2'b01,
    ESPERA_INICIAL = 2'b10,
    ESPERA_REPETE  = 2'b11
  } repeat_estado_t;

  // Opposing buttons cancel, so the code 2'b11 can never be produced.
  function automatic logic [1:0] codifica_eixo(input logic pos, input logic neg);
    logic [1:0] codigo;
    codigo = DIR_PARADO;
    if (pos && !neg) codigo = DIR_POS;
    else if (neg && !pos) codigo = DIR_NEG;
    return codigo;
  endfunction

endpackage

// File: rtl/debouncer_botao.sv
// One push-button conditioner: two-flop synchronizer followed by a debouncer.
// The accepted level only toggles after DEBOUNCE_CICLOS consecutive cycles
// of disagreement between the synchronized input and the held level.
module debouncer_botao #(
  parameter int DEBOUNCE_CICLOS = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_botao,
  output logic o_estavel
);

  localparam int W_CNT = $clog2(DEBOUNCE_CICLOS) + 1;
  localparam logic [W_CNT-1:0] CNT_TC  = W_CNT'(DEBOUNCE_CICLOS - 1);
  localparam logic [W_CNT-1:0] CNT_UM  = W_CNT'(1);

  logic             r_sync_0;
  logic             r_sync_1;
  logic             r_estavel;
  logic [W_CNT-1:0] r_cnt;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync_0 <= 1'b0;
      r_sync_1 <= 1'b0;
    end else begin
      r_sync_0 <= i_botao;
      r_sync_1 <= r_sync_0;
    end
  end

  // Count disagreement cycles; accept the new level at terminal count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estavel <= 1'b0;
      r_cnt     <= '0;
    end else if (r_sync_1 == r_estavel) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_TC) begin
      r_estavel <= ~r_estavel;
      r_cnt     <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_UM;
    end
  end

  assign o_estavel = r_estavel;

endmodule

// File: rtl/controle_joystick.sv
// Joystick input front-end: debounces six buttons, encodes the two direction
// axes and produces one-cycle iniciar/confirma pulses on accepted presses.
// Optional feature macro: CONTROLE_AUTOREPEAT_EN turns the direction outputs
// into auto-repeat pulses driven by one sequencer per axis; when undefined
// the axes are plain registered levels.
module controle_joystick
  import controle_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 1000,
  parameter int REPEAT_ATRASO   = 500000,
  parameter int REPEAT_PERIODO  = 200000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       botao_cima,
  input  logic       botao_baixo,
  input  logic       botao_esquerda,
  input  logic       botao_direita,
  input  logic       botao_confirma,
  input  logic       botao_iniciar,
  output logic [1:0] controle_vertical,
  output logic [1:0] controle_horizontal,
  output logic       confirma,
  output logic       iniciar,
  output logic [5:0] db_botoes
);

  // Bit order matches db_botoes: {iniciar, confirma, direita, esquerda, baixo, cima}.
  localparam int B_CIMA     = 0;
  localparam int B_BAIXO    = 1;
  localparam int B_ESQUERDA = 2;
  localparam int B_DIREITA  = 3;
  localparam int B_CONFIRMA = 4;
  localparam int B_INICIAR  = 5;

  if (DEBOUNCE_CICLOS < 2 || REPEAT_ATRASO < 1 || REPEAT_PERIODO < 1) begin : g_parametros_invalidos
    $error("controle_joystick: invalid timing parameters");
  end

  logic [5:0] w_bruto;
  logic [5:0] w_estavel;
  logic [1:0] w_codigo_vert;
  logic [1:0] w_codigo_horiz;

  assign w_bruto = {botao_iniciar, botao_confirma, botao_direita,
                    botao_esquerda, botao_baixo, botao_cima};

  for (genvar b = 0; b < 6; b++) begin : g_botao
    debouncer_botao #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_debouncer (
      .clock    (clock),
      .reset    (reset),
      .i_botao  (w_bruto[b]),
      .o_estavel(w_estavel[b])
    );
  end

  assign db_botoes      = w_estavel;
  assign w_codigo_vert  = codifica_eixo(w_estavel[B_CIMA], w_estavel[B_BAIXO]);
  assign w_codigo_horiz = codifica_eixo(w_estavel[B_ESQUERDA], w_estavel[B_DIREITA]);

  logic r_confirma_ant;
  logic r_iniciar_ant;
  logic r_confirma;
  logic r_iniciar;

  // Rising-edge detect of the debounced levels; lands on the same edge as
  // the registered direction outputs so simultaneous presses line up.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_confirma_ant <= 1'b0;
      r_iniciar_ant  <= 1'b0;
      r_confirma     <= 1'b0;
      r_iniciar      <= 1'b0;
    end else begin
      r_confirma_ant <= w_estavel[B_CONFIRMA];
      r_iniciar_ant  <= w_estavel[B_INICIAR];
      r_confirma     <= w_estavel[B_CONFIRMA] & ~r_confirma_ant;
      r_iniciar      <= w_estavel[B_INICIAR] & ~r_iniciar_ant;
    end
  end

  assign confirma = r_confirma;
  assign iniciar  = r_iniciar;

`ifdef CONTROLE_AUTOREPEAT_EN

  localparam int MAX_TEMPO = (REPEAT_ATRASO > REPEAT_PERIODO) ? REPEAT_ATRASO : REPEAT_PERIODO;
  localparam int W_TEMPO   = $clog2(MAX_TEMPO) + 1;
  localparam logic [W_TEMPO-1:0] ATRASO_TC  = W_TEMPO'(REPEAT_ATRASO - 1);
  localparam logic [W_TEMPO-1:0] PERIODO_TC = W_TEMPO'(REPEAT_PERIODO - 1);
  localparam logic [W_TEMPO-1:0] TEMPO_UM   = W_TEMPO'(1);

  logic [3:0] w_codigo_eixos;
  logic [3:0] w_saida_eixos;

  assign w_codigo_eixos = {w_codigo_horiz, w_codigo_vert};

  // Axis sequencer states:
  //   state          | meaning
  //   OCIOSO         | axis released, output 00
  //   PULSO          | one-cycle pulse with the current code
  //   ESPERA_INICIAL | long wait after the first pulse, output 00
  //   ESPERA_REPETE  | short wait between repeat pulses, output 00
  for (genvar e = 0; e < 2; e++) begin : g_eixo
    repeat_estado_t     r_estado;
    logic [1:0]         r_codigo_ant;
    logic [1:0]         r_saida;
    logic               r_primeiro;
    logic [W_TEMPO-1:0] r_tempo;
    logic [1:0]         w_codigo;

    assign w_codigo = w_codigo_eixos[2*e +: 2];

    // Release forces idle; a new or changed code pulses immediately;
    // otherwise alternate pulse and down-counted wait.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_estado     <= OCIOSO;
        r_codigo_ant <= DIR_PARADO;
        r_saida      <= DIR_PARADO;
        r_primeiro   <= 1'b0;
        r_tempo      <= '0;
      end else if (w_codigo == DIR_PARADO) begin
        r_estado     <= OCIOSO;
        r_codigo_ant <= DIR_PARADO;
        r_saida      <= DIR_PARADO;
        r_primeiro   <= 1'b0;
        r_tempo      <= '0;
      end else if (r_estado == OCIOSO || w_codigo != r_codigo_ant) begin
        r_estado     <= PULSO;
        r_codigo_ant <= w_codigo;
        r_saida      <= w_codigo;
        r_primeiro   <= 1'b1;
      end else begin
        case (r_estado)
          PULSO: begin
            r_saida <= DIR_PARADO;
            if (r_primeiro) begin
              r_estado <= ESPERA_INICIAL;
              r_tempo  <= ATRASO_TC;
            end else begin
              r_estado <= ESPERA_REPETE;
              r_tempo  <= PERIODO_TC;
            end
          end
          ESPERA_INICIAL, ESPERA_REPETE: begin
            if (r_tempo == '0) begin
              r_estado   <= PULSO;
              r_saida    <= w_codigo;
              r_primeiro <= 1'b0;
            end else begin
              r_tempo <= r_tempo - TEMPO_UM;
            end
          end
          default: begin
            r_estado <= OCIOSO;
            r_saida  <= DIR_PARADO;
          end
        endcase
      end
    end

    assign w_saida_eixos[2*e +: 2] = r_saida;
  end

  assign controle_vertical   = w_saida_eixos[1:0];
  assign controle_horizontal = w_saida_eixos[3:2];

`else

  logic [1:0] r_vertical;
  logic [1:0] r_horizontal;

  // Level mode: register the encoded debounced levels.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vertical   <= DIR_PARADO;
      r_horizontal <= DIR_PARADO;
    end else begin
      r_vertical   <= w_codigo_vert;
      r_horizontal <= w_codigo_horiz;
    end
  end

  assign controle_vertical   = r_vertical;
  assign controle_horizontal = r_horizontal;

`endif

endmodule

// File: tb/tb_controle_joystick.sv
module tb_controle_joystick;

  logic       clock = 1'b0;
  logic       reset;
  logic       botao_cima, botao_baixo, botao_esquerda, botao_direita;
  logic       botao_confirma, botao_iniciar;
  logic [1:0] controle_vertical, controle_horizontal;
  logic       confirma, iniciar;
  logic [5:0] db_botoes;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  controle_joystick #(
    .DEBOUNCE_CICLOS(4),
    .REPEAT_ATRASO  (10),
    .REPEAT_PERIODO (5)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .botao_cima         (botao_cima),
    .botao_baixo        (botao_baixo),
    .botao_esquerda     (botao_esquerda),
    .botao_direita      (botao_direita),
    .botao_confirma     (botao_confirma),
    .botao_iniciar      (botao_iniciar),
    .controle_vertical  (controle_vertical),
    .controle_horizontal(controle_horizontal),
    .confirma           (confirma),
    .iniciar            (iniciar),
    .db_botoes          (db_botoes)
  );

  typedef struct {
    logic [5:0] botoes;   // {iniciar, confirma, direita, esquerda, baixo, cima}
    logic [1:0] vert;
    logic [1:0] horiz;
  } vetor_t;

  vetor_t tabela[10];

  task automatic verifica(input string nome, input logic [7:0] obtido, input logic [7:0] esperado);
    n_checks++;
    if (obtido !== esperado) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nome, obtido, esperado);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic passo(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic aplica(input logic [5:0] b);
    {botao_iniciar, botao_confirma, botao_direita,
     botao_esquerda, botao_baixo, botao_cima} = b;
  endtask

  initial begin
    int n_conf;
    int n_ini;
    int borda_pulso;
    bit horiz_sujo;
    int offs[$];
    int offs_esp[6];

    tabela[0] = '{6'b000000, 2'b00, 2'b00};
    tabela[1] = '{6'b000001, 2'b01, 2'b00};
    tabela[2] = '{6'b000010, 2'b10, 2'b00};
    tabela[3] = '{6'b000011, 2'b00, 2'b00};
    tabela[4] = '{6'b000100, 2'b00, 2'b01};
    tabela[5] = '{6'b001000, 2'b00, 2'b10};
    tabela[6] = '{6'b001100, 2'b00, 2'b00};
    tabela[7] = '{6'b001001, 2'b01, 2'b10};
    tabela[8] = '{6'b111111, 2'b00, 2'b00};
    tabela[9] = '{6'b000110, 2'b10, 2'b01};

    // Reset state
    reset = 1'b1;
    aplica(6'b000000);
    passo(10);
    verifica("rst_vert", {6'd0, controle_vertical}, 8'h00);
    verifica("rst_horiz", {6'd0, controle_horizontal}, 8'h00);
    verifica("rst_pulsos", {6'd0, confirma, iniciar}, 8'h00);
    verifica("rst_db", {2'd0, db_botoes}, 8'h00);
    reset = 1'b0;
    passo(2);

    // Press latency on cima: new level on the 7th edge after the change
    botao_cima = 1'b1;
    passo(5);
    verifica("cima_db_antes", {7'd0, db_botoes[0]}, 8'h00);
    passo(1);
    verifica("cima_db", {7'd0, db_botoes[0]}, 8'h01);
`ifndef CONTROLE_AUTOREPEAT_EN
    verifica("cima_vert_antes", {6'd0, controle_vertical}, 8'h00);
`endif
    passo(1);
    verifica("cima_vert", {6'd0, controle_vertical}, 8'h01);
    passo(3);
    botao_cima = 1'b0;
`ifndef CONTROLE_AUTOREPEAT_EN
    passo(6);
    verifica("solta_vert_antes", {6'd0, controle_vertical}, 8'h01);
    passo(1);
    verifica("solta_vert", {6'd0, controle_vertical}, 8'h00);
`else
    passo(7);
`endif
    verifica("solta_db", {7'd0, db_botoes[0]}, 8'h00);
    passo(4);

    // Steady-state table
    for (int i = 0; i < 10; i++) begin
      aplica(tabela[i].botoes);
      passo(8);
      verifica($sformatf("tab%0d_db", i), {2'd0, db_botoes}, {2'd0, tabela[i].botoes});
`ifndef CONTROLE_AUTOREPEAT_EN
      verifica($sformatf("tab%0d_vert", i), {6'd0, controle_vertical}, {6'd0, tabela[i].vert});
      verifica($sformatf("tab%0d_horiz", i), {6'd0, controle_horizontal}, {6'd0, tabela[i].horiz});
`endif
      verifica($sformatf("tab%0d_pulsos", i), {6'd0, confirma, iniciar}, 8'h00);
    end
    aplica(6'b000000);
    passo(12);

    // Glitch of 3 cycles is rejected
    botao_confirma = 1'b1;
    passo(3);
    botao_confirma = 1'b0;
    n_conf = 0;
    for (int e = 0; e < 14; e++) begin
      passo(1);
      if (confirma) n_conf++;
      if (db_botoes[4]) n_conf += 100;
    end
    verifica("glitch3", n_conf[7:0], 8'd0);

    // Exactly 4 cycles is accepted as one press
    botao_confirma = 1'b1;
    passo(4);
    botao_confirma = 1'b0;
    n_conf = 0;
    for (int e = 0; e < 16; e++) begin
      passo(1);
      if (confirma) n_conf++;
    end
    verifica("glitch4", n_conf[7:0], 8'd1);

    // Held 20 cycles: one pulse on the 7th edge, none on release
    botao_confirma = 1'b1;
    n_conf = 0;
    borda_pulso = 0;
    for (int e = 1; e <= 20; e++) begin
      passo(1);
      if (confirma) begin
        n_conf++;
        borda_pulso = e;
      end
    end
    verifica("conf_pulsos", n_conf[7:0], 8'd1);
    verifica("conf_borda", borda_pulso[7:0], 8'd7);
    botao_confirma = 1'b0;
    n_conf = 0;
    for (int e = 0; e < 12; e++) begin
      passo(1);
      if (confirma) n_conf++;
    end
    verifica("conf_solta", n_conf[7:0], 8'd0);

    // cima+baixo cancel, dropping baixo gives up; horizontal stays idle
`ifndef CONTROLE_AUTOREPEAT_EN
    horiz_sujo = 1'b0;
    botao_cima = 1'b1;
    botao_baixo = 1'b1;
    for (int e = 0; e < 10; e++) begin
      passo(1);
      if (controle_horizontal != 2'b00) horiz_sujo = 1'b1;
    end
    verifica("ambos_vert", {6'd0, controle_vertical}, 8'h00);
    botao_baixo = 1'b0;
    for (int e = 0; e < 6; e++) begin
      passo(1);
      if (controle_horizontal != 2'b00) horiz_sujo = 1'b1;
    end
    verifica("cancel_antes", {6'd0, controle_vertical}, 8'h00);
    passo(1);
    verifica("cancel_vert", {6'd0, controle_vertical}, 8'h01);
    verifica("cancel_horiz", {7'd0, horiz_sujo}, 8'h00);
    botao_cima = 1'b0;
    passo(12);
`endif

    // iniciar and direita together respond on the same edge
    botao_iniciar = 1'b1;
    botao_direita = 1'b1;
    passo(6);
    verifica("simul_antes", {5'd0, iniciar, controle_horizontal}, 8'h00);
    passo(1);
    verifica("simul", {5'd0, iniciar, controle_horizontal}, 8'h06);
    passo(1);
    verifica("simul_largura", {7'd0, iniciar}, 8'h00);
    aplica(6'b000000);
    passo(12);

    // Reset while confirma held: cleared, then one fresh pulse
    botao_confirma = 1'b1;
    botao_cima = 1'b1;
    passo(10);
    verifica("pre_rst_db", {2'd0, db_botoes}, 8'h11);
    reset = 1'b1;
    passo(1);
    verifica("pos_rst_db", {2'd0, db_botoes}, 8'h00);
    verifica("pos_rst_saidas", {3'd0, controle_vertical, controle_horizontal, confirma}, 8'h00);
    reset = 1'b0;
    n_conf = 0;
    borda_pulso = 0;
    for (int e = 1; e <= 12; e++) begin
      passo(1);
      if (confirma) begin
        n_conf++;
        borda_pulso = e;
      end
    end
    verifica("rst_conf_pulsos", n_conf[7:0], 8'd1);
    verifica("rst_conf_borda", borda_pulso[7:0], 8'd7);
    aplica(6'b000000);
    passo(12);

`ifdef CONTROLE_AUTOREPEAT_EN
    // Auto-repeat on baixo held for 40 cycles
    offs_esp = '{0, 11, 17, 23, 29, 35};
    horiz_sujo = 1'b0;
    botao_baixo = 1'b1;
    for (int e = 1; e <= 80; e++) begin
      passo(1);
      if (e == 40) botao_baixo = 1'b0;
      if (controle_horizontal != 2'b00) horiz_sujo = 1'b1;
      if (controle_vertical != 2'b00) begin
        verifica("rep_codigo", {6'd0, controle_vertical}, 8'h02);
        offs.push_back(e);
      end
    end
    verifica("rep_horiz", {7'd0, horiz_sujo}, 8'h00);
    verifica("rep_n", offs.size(), 8'd6);
    if (offs.size() == 6) begin
      for (int i = 0; i < 6; i++)
        verifica($sformatf("rep_off%0d", i), 8'(offs[i] - offs[0]), offs_esp[i][7:0]);
      verifica("rep_primeiro", offs[0][7:0], 8'd7);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
